pc_fetch_ctrl: RTL and testbench



---
 rtl/pc_fetch_ctrl.sv | 129 ++++++++++++
 tb/tb_pc_fetch_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: architectural PC and fetch sequencing for the MIPS core.
// Resolves next PC (jr > jump > branch > pc+4) under imem_ready/stall.
// Ports: clk, rst (async, active-high), stall, imem_ready, jump, jtarget,
//   branch_taken, branch_imm, jr, jr_addr -> pc_out, pc_plus4,
//   fetch_valid, misalign_fault (sticky until rst).
// Option: define PC_DELAY_SLOT_EN for a one-instruction branch delay slot.
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        imem_ready,
    input  logic        jump,
    input  logic [25:0] jtarget,
    input  logic        branch_taken,
    input  logic [15:0] branch_imm,
    input  logic        jr,
    input  logic [31:0] jr_addr,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4,
    output logic        fetch_valid,
    output logic        misalign_fault
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] jump_tgt, br_tgt, redir_tgt;
    logic        advance, misalign;
    logic        sel_jr, sel_j, sel_b;

`ifdef PC_DELAY_SLOT_EN
    logic        pend_q, pend_d;
    logic [31:0] tgt_q, tgt_d;
    logic        redirect;
    assign redirect = jr | jump | branch_taken;
`endif

    assign pc_out   = pc_q;
    assign pc_plus4 = pc_q + 32'd4;

    assign jump_tgt = {pc_plus4[31:28], jtarget, 2'b00};
    assign br_tgt   = pc_plus4 + {{14{branch_imm[15]}}, branch_imm, 2'b00};

    // One-hot selects so the lower-priority requests are dropped.
    assign sel_jr = jr;
    assign sel_j  = jump & ~jr;
    assign sel_b  = branch_taken & ~jump & ~jr;

    assign advance  = (state_q == FETCH) && imem_ready && !stall;
    assign misalign = jr && (jr_addr[1:0] != 2'b00);

    always_comb begin
        redir_tgt = pc_plus4;
        unique case (1'b1)
            sel_jr:  redir_tgt = jr_addr;
            sel_j:   redir_tgt = jump_tgt;
            sel_b:   redir_tgt = br_tgt;
            default: redir_tgt = pc_plus4;
        endcase
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
`ifdef PC_DELAY_SLOT_EN
        pend_d  = pend_q;
        tgt_d   = tgt_q;
`endif
        case (state_q)
            BOOT:  state_d = FETCH;
            FETCH: begin
                if (advance) begin
`ifdef PC_DELAY_SLOT_EN
                    // Slot instruction: controls ignored, take the target.
                    if (pend_q) begin
                        pc_d   = tgt_q;
                        pend_d = 1'b0;
                    end else if (misalign) begin
                        state_d = FAULT;
                    end else begin
                        pc_d = pc_plus4;
                        if (redirect) begin
                            tgt_d  = redir_tgt;
                            pend_d = 1'b1;
                        end
                    end
`else
                    if (misalign) begin
                        state_d = FAULT;
                    end else begin
                        pc_d = redir_tgt;
                    end
`endif
                end
            end
            FAULT:   state_d = FAULT;
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
`ifdef PC_DELAY_SLOT_EN
            pend_q  <= 1'b0;
            tgt_q   <= 32'd0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
`ifdef PC_DELAY_SLOT_EN
            pend_q  <= pend_d;
            tgt_q   <= tgt_d;
`endif
        end
    end

    assign fetch_valid    = (state_q == FETCH);
    assign misalign_fault = (state_q == FAULT);

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl: directed table plus randomized run against a
// behavioural next-PC model for pc_fetch_ctrl.
module tb_pc_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, imem_ready, jump, branch_taken, jr;
    logic [25:0] jtarget;
    logic [15:0] branch_imm;
    logic [31:0] jr_addr;
    logic [31:0] pc_out, pc_plus4, w_pc, w_p4;
    logic        fetch_valid, misalign_fault, w_fv, w_mf;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pc_fetch_ctrl dut (
        .clk(clk), .rst(rst), .stall(stall), .imem_ready(imem_ready),
        .jump(jump), .jtarget(jtarget), .branch_taken(branch_taken),
        .branch_imm(branch_imm), .jr(jr), .jr_addr(jr_addr),
        .pc_out(pc_out), .pc_plus4(pc_plus4),
        .fetch_valid(fetch_valid), .misalign_fault(misalign_fault)
    );

    pc_fetch_ctrl #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .rst(rst), .stall(stall), .imem_ready(imem_ready),
        .jump(jump), .jtarget(jtarget), .branch_taken(branch_taken),
        .branch_imm(branch_imm), .jr(jr), .jr_addr(jr_addr),
        .pc_out(w_pc), .pc_plus4(w_p4),
        .fetch_valid(w_fv), .misalign_fault(w_mf)
    );

    typedef struct {
        logic        stall, ready, jump;
        logic [25:0] jt;
        logic        br;
        logic [15:0] imm;
        logic        jr;
        logic [31:0] ja;
        logic [31:0] epc;
        logic        efv, emf;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic s, logic r, logic j, logic [25:0] jt,
                                logic b, logic [15:0] imm, logic r2,
                                logic [31:0] ja, logic [31:0] epc,
                                logic efv, logic emf);
        vec_t v;
        v.stall = s; v.ready = r; v.jump = j; v.jt = jt; v.br = b;
        v.imm = imm; v.jr = r2; v.ja = ja; v.epc = epc;
        v.efv = efv; v.emf = emf;
        return v;
    endfunction

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        stall = 0; imem_ready = 0; jump = 0; jtarget = '0;
        branch_taken = 0; branch_imm = '0; jr = 0; jr_addr = '0;
    endtask

    task automatic rand_inputs();
        logic [31:0] t;
        stall        = ($urandom % 5) == 0;
        imem_ready   = ($urandom % 4) != 0;
        jump         = ($urandom % 6) == 0;
        jtarget      = 26'($urandom);
        branch_taken = ($urandom % 5) == 0;
        branch_imm   = 16'($urandom);
        jr           = ($urandom % 8) == 0;
        t            = $urandom;
        jr_addr      = (($urandom % 12) == 0) ? t : (t & 32'hFFFF_FFFC);
    endtask

    // Reference model: phase 0 = booting, 1 = running, 2 = faulted.
    int          m_phase;
    logic [31:0] m_pc, m_pend;
    bit          m_pv;

    task automatic model_reset();
        m_phase = 0; m_pc = 32'h0040_0000; m_pend = 0; m_pv = 0;
    endtask

    task automatic model_step();
        logic [31:0] seq, tgt;
        bit redir;
        seq = m_pc + 4;
        if (m_phase == 0) begin
            m_phase = 1;
        end else if (m_phase == 1 && imem_ready && !stall) begin
            if (m_pv) begin
                m_pc = m_pend;
                m_pv = 0;
            end else if (jr && (jr_addr % 4) != 0) begin
                m_phase = 2;
            end else begin
                redir = jr || jump || branch_taken;
                if (jr)
                    tgt = jr_addr;
                else if (jump)
                    tgt = (seq & 32'hF000_0000) | (32'(jtarget) * 4);
                else if (branch_taken)
                    tgt = seq + 32'(int'($signed(branch_imm)) * 4);
                else
                    tgt = seq;
`ifdef PC_DELAY_SLOT_EN
                m_pc = seq;
                if (redir) begin
                    m_pend = tgt;
                    m_pv = 1;
                end
`else
                if (redir) m_pc = tgt;
                else m_pc = seq;
`endif
            end
        end
    endtask

    task automatic check_model(string tag);
        check({tag, "_pc"}, pc_out, m_pc);
        check({tag, "_p4"}, pc_plus4, m_pc + 32'd4);
        check({tag, "_fv"}, 32'(fetch_valid), 32'(m_phase == 1));
        check({tag, "_mf"}, 32'(misalign_fault), 32'(m_phase == 2));
    endtask

    initial begin
        tbl.push_back(mk(0,1,0,0,0,0,0,0, 32'h0040_0000,1,0));
        tbl.push_back(mk(0,1,0,0,0,0,0,0, 32'h0040_0004,1,0));
        tbl.push_back(mk(0,1,0,0,0,0,0,0, 32'h0040_0008,1,0));
        tbl.push_back(mk(0,1,0,0,0,0,0,0, 32'h0040_000C,1,0));
        tbl.push_back(mk(0,1,0,0,0,0,0,0, 32'h0040_0010,1,0));
`ifdef PC_DELAY_SLOT_EN
        tbl.push_back(mk(0,1,1,26'h0100008,0,0,0,0, 32'h0040_0014,1,0));
        tbl.push_back(mk(0,1,0,0,0,0,0,0, 32'h0040_0020,1,0));
        tbl.push_back(mk(0,1,0,0,1,16'hFFFE,0,0, 32'h0040_0024,1,0));
        tbl.push_back(mk(0,1,0,0,0,0,0,0, 32'h0040_001C,1,0));
`else
        tbl.push_back(mk(0,1,1,26'h0100008,0,0,0,0, 32'h0040_0020,1,0));
        tbl.push_back(mk(0,1,0,0,1,16'hFFFE,0,0, 32'h0040_001C,1,0));
`endif
        tbl.push_back(mk(0,0,1,26'h0100008,1,16'hFFFE,1,32'h0040_0100,
                         32'h0040_001C,1,0));
        tbl.push_back(mk(1,1,1,26'h0100008,1,16'hFFFE,1,32'h0040_0100,
                         32'h0040_001C,1,0));
        tbl.push_back(mk(1,0,1,26'h0100008,1,16'hFFFE,1,32'h0040_0100,
                         32'h0040_001C,1,0));
`ifdef PC_DELAY_SLOT_EN
        tbl.push_back(mk(0,1,1,26'h0100008,1,16'hFFFE,1,32'h0040_0100,
                         32'h0040_0020,1,0));
        tbl.push_back(mk(0,1,0,0,0,0,0,0, 32'h0040_0100,1,0));
`else
        tbl.push_back(mk(0,1,1,26'h0100008,1,16'hFFFE,1,32'h0040_0100,
                         32'h0040_0100,1,0));
`endif
        tbl.push_back(mk(0,1,0,0,0,0,0,0, 32'h0040_0104,1,0));
        tbl.push_back(mk(0,1,0,0,0,0,1,32'h0040_0006, 32'h0040_0104,0,1));

        // Reset and boot.
        idle_inputs();
        rst = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_pc", pc_out, 32'h0040_0000);
        check("rst_fv", 32'(fetch_valid), 0);
        check("rst_mf", 32'(misalign_fault), 0);
        rst = 0;
        #1;
        check("boot_pc", pc_out, 32'h0040_0000);
        check("boot_fv", 32'(fetch_valid), 0);

        foreach (tbl[i]) begin
            stall = tbl[i].stall; imem_ready = tbl[i].ready;
            jump = tbl[i].jump; jtarget = tbl[i].jt;
            branch_taken = tbl[i].br; branch_imm = tbl[i].imm;
            jr = tbl[i].jr; jr_addr = tbl[i].ja;
            @(posedge clk);
            @(negedge clk);
            check($sformatf("vec%0d_pc", i), pc_out, tbl[i].epc);
            check($sformatf("vec%0d_p4", i), pc_plus4, tbl[i].epc + 4);
            check($sformatf("vec%0d_fv", i), 32'(fetch_valid),
                  32'(tbl[i].efv));
            check($sformatf("vec%0d_mf", i), 32'(misalign_fault),
                  32'(tbl[i].emf));
            if (i == 0) begin
                check("wrap_top_pc", w_pc, 32'hFFFF_FFFC);
                check("wrap_top_p4", w_p4, 32'h0000_0000);
            end
            if (i == 1) begin
                check("wrap_pc", w_pc, 32'h0000_0000);
                check("wrap_fv", 32'(w_fv), 1);
                check("wrap_mf", 32'(w_mf), 0);
            end
        end

        // Fault must freeze everything for 10 cycles of random inputs.
        for (int k = 0; k < 10; k++) begin
            rand_inputs();
            imem_ready = 1; stall = 0;
            @(posedge clk);
            @(negedge clk);
            check($sformatf("fault%0d_pc", k), pc_out, 32'h0040_0104);
            check($sformatf("fault%0d_fv", k), 32'(fetch_valid), 0);
            check($sformatf("fault%0d_mf", k), 32'(misalign_fault), 1);
        end

        // Asynchronous reset out of FAULT.
        rst = 1;
        #1;
        check("fault_rst_pc", pc_out, 32'h0040_0000);
        check("fault_rst_mf", 32'(misalign_fault), 0);
        @(posedge clk);
        @(negedge clk);
        rst = 0;
        model_reset();

        // Randomized run against the model.
        for (int n = 0; n < 600; n++) begin
            if ((m_phase == 2 && ($urandom % 4) == 0) ||
                ($urandom % 97) == 0) begin
                rst = 1;
                model_reset();
                #1;
                check_model("rnd_arst");
                @(posedge clk);
                @(negedge clk);
                rst = 0;
            end else begin
                rand_inputs();
                model_step();
                @(posedge clk);
                @(negedge clk);
                check_model("rnd");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
